// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: enable, divisor
// load handshake, and the divided outputs.
interface clk_div_prog_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             div_ack;
   logic             div_err;
   logic [CNT_W-1:0] div_cur;
   logic             tick;
   logic             out_clk;

   modport master (
      output en, div_in, div_load,
      input  div_ack, div_err, div_cur, tick, out_clk
   );

   modport slave (
      input  en, div_in, div_load,
      output div_ack, div_err, div_cur, tick, out_clk
   );
endinterface

// File: rtl/clk_div_prog.sv
// Run-time programmable clock divider: one-cycle tick plus near-50% out_clk at
// f_clk/D, with new divisors applied only on period boundaries.
module clk_div_prog #(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 20
) (
   input logic           clk,
   input logic           rst,
   clk_div_prog_if.slave bus
);

   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_DIV);

   if ((DEF_DIV < 1) || (DEF_DIV > ((1 << CNT_W) - 1))) begin : g_def_div_chk
      $error("clk_div_prog: DEF_DIV out of range 1..2^CNT_W-1");
   end

   // phase holds the phase entered on the next enabled edge
   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] phase_nxt;
   logic [CNT_W-1:0] div_cur_p1;
   logic [CNT_W-1:0] pend;
   logic             pend_vld;
   logic [CNT_W-1:0] d_eff;
   logic [CNT_W-1:0] h_eff;
   logic             load_ok;
   logic             apply;
   logic             tick_p1;
   logic             out_clk_p1;
   logic             ack_p1;
   logic             err_p1;

   function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
      half_up = d - (d >> 1);
   endfunction

   always_comb begin
      load_ok   = bus.div_load && (bus.div_in != '0);
      // A pending divisor takes over exactly when phase 0 is entered
      apply     = bus.en && pend_vld && (phase == '0);
      d_eff     = apply ? pend : div_cur_p1;
      h_eff     = half_up(d_eff);
      phase_nxt = (phase == (d_eff - CNT_W'(1))) ? '0 : (phase + CNT_W'(1));
   end

   // ---- stage p1: registered outputs for the phase being entered ----
   always_ff @(posedge clk) begin
      if (rst) begin
         phase      <= '0;
         div_cur_p1 <= DEF_D;
         pend_vld   <= 1'b0;
         tick_p1    <= 1'b0;
         out_clk_p1 <= 1'b0;
         ack_p1     <= 1'b0;
         err_p1     <= 1'b0;
      end else begin
         ack_p1  <= apply;
         err_p1  <= bus.div_load && (bus.div_in == '0);
         tick_p1 <= 1'b0;
         if (bus.en) begin
            phase      <= phase_nxt;
            tick_p1    <= (phase == '0);
            out_clk_p1 <= (phase < h_eff);
         end
         if (apply) begin
            div_cur_p1 <= pend;
         end
         // A load on the applying edge stays pending for the following boundary
         if (load_ok) begin
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_ok) begin
         pend <= bus.div_in;
      end
   end

   assign bus.tick    = tick_p1;
   assign bus.out_clk = out_clk_p1;
   assign bus.div_ack = ack_p1;
   assign bus.div_err = err_p1;
   assign bus.div_cur = div_cur_p1;

endmodule
